// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the frame-buffer arbiter.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISP    = 2'd1,
        S_WRITE   = 2'd2,
        S_FORCE_W = 2'd3
    } state_t;

    localparam int AW_DEF = 19;
    localparam int DW_DEF = 8;

    // Width needed to count 0..lim inclusive.
    function automatic int cnt_width(input int lim);
        return $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/fb_arb_if.sv
// Requester and RAM-side bundle of the frame-buffer arbiter.
interface fb_arb_if #(
    parameter int AW = fb_arb_pkg::AW_DEF,
    parameter int DW = fb_arb_pkg::DW_DEF
);
    logic          D_REQ;
    logic [AW-1:0] D_ADR;
    logic          D_ACK;
    logic [DW-1:0] D_DATA;
    logic          D_VALID;
    logic          W_REQ;
    logic [AW-1:0] W_ADR;
    logic [DW-1:0] W_DATA;
    logic          W_ACK;
    logic          M_EN;
    logic          M_WE;
    logic [AW-1:0] M_ADR;
    logic [DW-1:0] M_WDATA;
    logic [DW-1:0] M_RDATA;

    modport slave (
        input  D_REQ, D_ADR, W_REQ, W_ADR, W_DATA, M_RDATA,
        output D_ACK, D_DATA, D_VALID, W_ACK, M_EN, M_WE, M_ADR, M_WDATA
    );

    modport master (
        output D_REQ, D_ADR, W_REQ, W_ADR, W_DATA, M_RDATA,
        input  D_ACK, D_DATA, D_VALID, W_ACK, M_EN, M_WE, M_ADR, M_WDATA
    );
endinterface

// File: rtl/fb_rd_pipe.sv
// Read-return tracker: follows each issued read through the RAM latency
// and presents its data to the display, holding the last word otherwise.
module fb_rd_pipe #(
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_issue,
    input  logic [DW-1:0] i_rdata,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);
    logic [RD_LAT-1:0] r_vld_sr;
    logic [DW-1:0]     r_last;

    // Shift a marker per read so it emerges when the RAM data is valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= (r_vld_sr << 1) | RD_LAT'(i_issue);
        end
    end

    // Remember the last returned word so D_DATA is stable between returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= '0;
        end else if (o_valid) begin
            r_last <= i_rdata;
        end
    end

    // RAM data passes straight through in its valid cycle; no extra stage.
    assign o_valid = r_vld_sr[RD_LAT-1];
    assign o_data  = o_valid ? i_rdata : r_last;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads have priority, the
// pattern writer is guaranteed one grant after STARVE_LIM display grants.
//
// state     | meaning
// S_IDLE    | no grant last cycle
// S_DISP    | display granted last cycle
// S_WRITE   | writer granted last cycle
// S_FORCE_W | starvation limit reached, writer goes next
module fb_arbiter
    import fb_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic     CLK,
    input  logic     NRST,
    fb_arb_if.slave  bus
);
    localparam int            CW  = cnt_width(STARVE_LIM);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_d_ack;
    logic          w_w_ack;
    logic          r_m_en;
    logic          r_m_we;
    logic [AW-1:0] r_m_adr;
    logic [DW-1:0] r_m_wdata;
    logic          w_d_valid;
    logic [DW-1:0] w_d_data;

    // Grant decision, next fairness state and starvation count.
    // ACKs are held low while NRST is asserted so every output reads 0.
    always_comb begin
        w_d_ack     = 1'b0;
        w_w_ack     = 1'b0;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        if (NRST) begin
            if (r_state == S_FORCE_W && bus.W_REQ) begin
                w_w_ack     = 1'b1;
                w_state_nxt = S_WRITE;
            end else if (bus.D_REQ) begin
                w_d_ack     = 1'b1;
                w_state_nxt = S_DISP;
                if (bus.W_REQ) begin
                    w_cnt_nxt = (r_cnt >= LIM) ? LIM : r_cnt + 1'b1;
                    if (w_cnt_nxt == LIM) begin
                        w_state_nxt = S_FORCE_W;
                    end
                end
            end else if (bus.W_REQ) begin
                w_w_ack     = 1'b1;
                w_state_nxt = S_WRITE;
            end
        end
    end

    // Fairness state and starvation counter registers.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // RAM command registers; address/data hold when nothing is granted.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_m_en    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_adr   <= '0;
            r_m_wdata <= '0;
        end else begin
            r_m_en <= w_d_ack | w_w_ack;
            r_m_we <= w_w_ack;
            if (w_w_ack) begin
                r_m_adr   <= bus.W_ADR;
                r_m_wdata <= bus.W_DATA;
            end else if (w_d_ack) begin
                r_m_adr   <= bus.D_ADR;
            end
        end
    end

    fb_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (CLK),
        .i_rst_n (NRST),
        .i_issue (r_m_en & ~r_m_we),
        .i_rdata (bus.M_RDATA),
        .o_valid (w_d_valid),
        .o_data  (w_d_data)
    );

    assign bus.D_ACK   = w_d_ack;
    assign bus.W_ACK   = w_w_ack;
    assign bus.M_EN    = r_m_en;
    assign bus.M_WE    = r_m_we;
    assign bus.M_ADR   = r_m_adr;
    assign bus.M_WDATA = r_m_wdata;
    assign bus.D_VALID = w_d_valid;
    assign bus.D_DATA  = w_d_data;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed and random bench for fb_arbiter with a RAM model and a
// read-data scoreboard.
module tb_fb_arbiter;
    localparam int AW         = 19;
    localparam int DW         = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_LIM = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic CLK  = 1'b0;
    logic NRST = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   wait_cnt = 0;
    logic [DW-1:0] last_data = '0;
    exp_t q[$];
    logic [DW-1:0] ram    [int];
    logic [DW-1:0] shadow [int];
    logic [DW-1:0] rp     [RD_LAT];

    fb_arb_if #(.AW(AW), .DW(DW)) bus ();

    fb_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .CLK  (CLK),
        .NRST (NRST),
        .bus  (bus)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 8'(a) ^ 8'h3C;
    endfunction

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(int'(a)) ? ram[int'(a)] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model: write on M_EN&M_WE, read data appears RD_LAT edges later.
    always @(posedge CLK) begin
        if (bus.M_EN && bus.M_WE) ram[int'(bus.M_ADR)] = bus.M_WDATA;
        rp[0] <= (bus.M_EN && !bus.M_WE) ? ram_rd(bus.M_ADR) : 8'($urandom);
        for (int k = 1; k < RD_LAT; k++) rp[k] <= rp[k-1];
    end
    assign bus.M_RDATA = rp[RD_LAT-1];

    // Monitor: protocol rules, scoreboard push on grant, pop on return.
    always @(negedge CLK) begin
        exp_t e;
        if (!NRST) begin
            q.delete();
            wait_cnt  = 0;
            last_data = '0;
        end else begin
            chk("ack_both", 32'(bus.D_ACK & bus.W_ACK), 0);
            chk("d_ack_no_req", 32'(bus.D_ACK & ~bus.D_REQ), 0);
            chk("w_ack_no_req", 32'(bus.W_ACK & ~bus.W_REQ), 0);
            if (bus.D_VALID) begin
                chk("unexpected_valid", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("rd_data", 32'(bus.D_DATA), 32'(e.data));
                    chk("rd_latency", cyc, e.cyc);
                end
                last_data = bus.D_DATA;
            end else begin
                chk("d_data_hold", 32'(bus.D_DATA), 32'(last_data));
            end
            if (bus.D_ACK) begin
                q.push_back('{data: shadow_rd(bus.D_ADR), cyc: cyc + RD_LAT + 1});
                if (bus.W_REQ) begin
                    wait_cnt++;
                    chk("writer_starved", 32'(wait_cnt <= STARVE_LIM), 1);
                end
            end
            if (bus.W_ACK) begin
                shadow[int'(bus.W_ADR)] = bus.W_DATA;
                wait_cnt = 0;
            end
            if (!bus.W_REQ) wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input bit is_d, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 32 && !got; k++) begin
            @(negedge CLK);
            got = is_d ? bus.D_ACK : bus.W_ACK;
        end
        chk(tag, 32'(got), 1);
        step();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_d_ack"},   32'(bus.D_ACK), 0);
        chk({tag, "_w_ack"},   32'(bus.W_ACK), 0);
        chk({tag, "_d_valid"}, 32'(bus.D_VALID), 0);
        chk({tag, "_d_data"},  32'(bus.D_DATA), 0);
        chk({tag, "_m_en"},    32'(bus.M_EN), 0);
        chk({tag, "_m_we"},    32'(bus.M_WE), 0);
        chk({tag, "_m_adr"},   32'(bus.M_ADR), 0);
        chk({tag, "_m_wdata"}, 32'(bus.M_WDATA), 0);
    endtask

    // Both requesters held; expects STARVE_LIM display grants then one write.
    task automatic contend(input int n_grants, input string tag);
        bit gd, gw;
        bus.D_REQ = 1'b1;
        bus.W_REQ = 1'b1;
        for (int g = 0; g < n_grants; g++) begin
            @(negedge CLK);
            gd = bus.D_ACK;
            gw = bus.W_ACK;
            chk(tag, 32'({gd, gw}),
                (g % (STARVE_LIM + 1) == STARVE_LIM) ? 32'b01 : 32'b10);
            step();
            if (gd) bus.D_ADR = bus.D_ADR + 1'b1;
            if (gw) begin
                bus.W_ADR  = bus.W_ADR + 1'b1;
                bus.W_DATA = bus.W_DATA + 8'h11;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge CLK);
        chk("drain", q.size(), 0);
        step();
    endtask

    initial begin
        bit da, wa;
        bus.D_REQ  = 1'b0;
        bus.D_ADR  = '0;
        bus.W_REQ  = 1'b0;
        bus.W_ADR  = '0;
        bus.W_DATA = '0;

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check_zero("reset");
        NRST = 1'b1;
        step();

        // Display only, four consecutive addresses
        for (int a = 16; a < 20; a++) begin
            bus.D_REQ = 1'b1;
            bus.D_ADR = AW'(a);
            @(negedge CLK);
            chk("disp_ack_seq", 32'(bus.D_ACK), 1);
            step();
            chk("disp_m_en", 32'(bus.M_EN), 1);
            chk("disp_m_we", 32'(bus.M_WE), 0);
            chk("disp_m_adr", 32'(bus.M_ADR), a);
        end
        bus.D_REQ = 1'b0;
        step();
        chk("disp_m_en_off", 32'(bus.M_EN), 0);
        drain();

        // Writer only, then read back
        bus.W_REQ  = 1'b1;
        bus.W_ADR  = AW'(5);
        bus.W_DATA = 8'hA5;
        wait_ack(1'b0, "wr_ack");
        bus.W_REQ = 1'b0;
        chk("wr_m_en", 32'(bus.M_EN), 1);
        chk("wr_m_we", 32'(bus.M_WE), 1);
        chk("wr_m_adr", 32'(bus.M_ADR), 5);
        chk("wr_m_wdata", 32'(bus.M_WDATA), 32'hA5);
        step();
        chk("wr_m_en_off", 32'(bus.M_EN), 0);
        chk("wr_m_we_off", 32'(bus.M_WE), 0);
        chk("wr_m_adr_hold", 32'(bus.M_ADR), 5);
        bus.D_REQ = 1'b1;
        bus.D_ADR = AW'(5);
        wait_ack(1'b1, "rdback_ack");
        bus.D_REQ = 1'b0;
        drain();

        // Same-address write then read, back to back
        bus.W_REQ  = 1'b1;
        bus.W_ADR  = AW'(32);
        bus.W_DATA = 8'h5A;
        wait_ack(1'b0, "b2b_wr_ack");
        bus.W_REQ = 1'b0;
        bus.D_REQ = 1'b1;
        bus.D_ADR = AW'(32);
        wait_ack(1'b1, "b2b_rd_ack");
        bus.D_REQ = 1'b0;
        drain();

        // Priority: both rise with counter at 0
        bus.D_REQ = 1'b1;
        bus.D_ADR = AW'(64);
        bus.W_REQ = 1'b1;
        bus.W_ADR = AW'(65);
        bus.W_DATA = 8'h3E;
        @(negedge CLK);
        chk("prio_disp_first", 32'({bus.D_ACK, bus.W_ACK}), 32'b10);
        step();
        bus.D_REQ = 1'b0;
        @(negedge CLK);
        chk("prio_writer_next", 32'({bus.D_ACK, bus.W_ACK}), 32'b01);
        step();
        bus.W_REQ = 1'b0;
        drain();

        // Contention: three full fairness rounds
        bus.D_ADR  = AW'(256);
        bus.W_ADR  = AW'(512);
        bus.W_DATA = 8'h10;
        contend(3 * (STARVE_LIM + 1), "contend_pattern");

        // Reset mid-stream with two reads in flight and counter at 2
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            chk("pre_rst_d_ack", 32'(bus.D_ACK), 1);
            step();
            bus.D_ADR = bus.D_ADR + 1'b1;
        end
        #2;
        NRST = 1'b0;
        #1;
        check_zero("mid_rst");
        step();
        step();
        NRST = 1'b1;
        contend(STARVE_LIM + 1, "post_rst_pattern");
        bus.D_REQ = 1'b0;
        bus.W_REQ = 1'b0;
        drain();

        // Random traffic
        for (int c = 0; c < 1000; c++) begin
            @(negedge CLK);
            da = bus.D_ACK;
            wa = bus.W_ACK;
            step();
            if (!bus.D_REQ || da) begin
                bus.D_REQ = ($urandom_range(0, 3) != 0);
                bus.D_ADR = AW'($urandom_range(0, 31));
            end
            if (!bus.W_REQ || wa) begin
                bus.W_REQ  = 1'($urandom_range(0, 1));
                bus.W_ADR  = AW'($urandom_range(0, 31));
                bus.W_DATA = DW'($urandom);
            end
        end
        bus.D_REQ = 1'b0;
        bus.W_REQ = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
